// File: rtl/mux_scan_rx_if.sv
// Signal bundle between the scanning receiver and its environment: control, external mux pins
// and reassembled result words.
interface mux_scan_rx_if;
  logic       start;
  logic       cont;
  logic       busy;
  logic       G1_n;
  logic       G2_n;
  logic       S1;
  logic       S0;
  logic       Y1;
  logic       Y2;
  logic [3:0] Q1;
  logic [3:0] Q2;
  logic       valid;

  modport master (
    input  start, cont, Y1, Y2,
    output busy, G1_n, G2_n, S1, S0, Q1, Q2, valid
  );

  modport slave (
    output start, cont, Y1, Y2,
    input  busy, G1_n, G2_n, S1, S0, Q1, Q2, valid
  );
endinterface

// File: rtl/mux_scan_rx.sv
// Scanning receiver for a dual 4-to-1 mux link: steps the selects, samples both mux outputs per
// channel and publishes the two reassembled words together with a one-cycle valid pulse.
module mux_scan_rx #(
  parameter int unsigned SETTLE = 1
) (
  input logic          clk,
  input logic          rst,
  mux_scan_rx_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StSample, StDone} state_e;

  localparam logic [2:0] SettleCnt = 3'(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [3:0] q1_q, q1_d, q2_q, q2_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       g_n_q, g_n_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    g_n_d   = g_n_q;
    unique case (state_q)
      StIdle: begin
        idx_d  = 2'd0;
        sel_d  = 2'd0;
        g_n_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.start || bus.cont) begin
          state_d = StSetup;
          cnt_d   = SettleCnt;
          g_n_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = StSample;
      end
      StSample: begin
        sh1_d[idx_q] = bus.Y1;
        sh2_d[idx_q] = bus.Y2;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          sel_d   = idx_q + 2'd1;
          cnt_d   = SettleCnt;
          state_d = StSetup;
        end else begin
          // Last channel lands straight in Q so both words appear with the valid pulse.
          state_d = StDone;
          q1_d    = sh1_d;
          q2_d    = sh2_d;
          valid_d = 1'b1;
          g_n_d   = 1'b1;
        end
      end
      StDone: begin
        idx_d = 2'd0;
        sel_d = 2'd0;
        if (bus.start || bus.cont) begin
          state_d = StSetup;
          cnt_d   = SettleCnt;
          g_n_d   = 1'b0;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 3'd0;
      sh1_q   <= 4'd0;
      sh2_q   <= 4'd0;
      q1_q    <= 4'd0;
      q2_q    <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      g_n_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      g_n_q   <= g_n_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.G1_n  = g_n_q;
  assign bus.G2_n  = g_n_q;
  assign bus.S1    = sel_q[1];
  assign bus.S0    = sel_q[0];
  assign bus.Q1    = q1_q;
  assign bus.Q2    = q2_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_scan_rx.sv
// Bench for mux_scan_rx: two instances (SETTLE=1 and SETTLE=0) each driven by a model of the
// external dual mux; expectations come from the scan timing rules and per-channel sample times.
module tb_mux_scan_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_scan_rx_if bus1 ();
  mux_scan_rx_if bus0 ();

  mux_scan_rx #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_scan_rx #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Mux data words; output is junk whenever the strobe is high.
  logic [3:0] d1_a, d2_a, d1_b, d2_b;
  logic [3:0] junk;
  always @(negedge clk) junk = 4'($urandom);

  assign bus1.Y1 = bus1.G1_n ? junk[0] : d1_a[{bus1.S1, bus1.S0}];
  assign bus1.Y2 = bus1.G2_n ? junk[1] : d2_a[{bus1.S1, bus1.S0}];
  assign bus0.Y1 = bus0.G1_n ? junk[2] : d1_b[{bus0.S1, bus0.S0}];
  assign bus0.Y2 = bus0.G2_n ? junk[3] : d2_b[{bus0.S1, bus0.S0}];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] q1_1, q2_1, q1_0, q2_0;

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    bus1.start = 1'b1; bus1.cont = 1'b0;
    bus0.start = 1'b1; bus0.cont = 1'b1;
    d1_a = 4'hF; d2_a = 4'hF; d1_b = 4'hF; d2_b = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    got = {bus1.G1_n, bus1.G2_n, bus1.S1, bus1.S0, bus1.busy, bus1.valid};
    n_cmp++;
    if (got !== 6'b110000) begin
      n_fail++; $display("FAIL reset_ctl1 got %b want %b", got, 6'b110000);
    end
    n_cmp++;
    if ({bus1.Q1, bus1.Q2} !== 8'h00) begin
      n_fail++; $display("FAIL reset_q1 got %h want 00", {bus1.Q1, bus1.Q2});
    end
    got = {bus0.G1_n, bus0.G2_n, bus0.S1, bus0.S0, bus0.busy, bus0.valid};
    n_cmp++;
    if (got !== 6'b110000) begin
      n_fail++; $display("FAIL reset_ctl0 got %b want %b", got, 6'b110000);
    end
    n_cmp++;
    if ({bus0.Q1, bus0.Q2} !== 8'h00) begin
      n_fail++; $display("FAIL reset_q0 got %h want 00", {bus0.Q1, bus0.Q2});
    end
    rst = 1'b0;
    bus1.start = 1'b0; bus0.start = 1'b0; bus0.cont = 1'b0;
    q1_1 = 4'd0; q2_1 = 4'd0; q1_0 = 4'd0; q2_0 = 4'd0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus1.busy !== 1'b0 || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle busy got %b%b want 00", bus1.busy, bus0.busy);
    end
  endtask

  // One scan on the SETTLE=1 instance: 3 cycles per channel, DONE at cycle 12, IDLE at 13.
  task automatic run_scan1(input logic [3:0] i1, input logic [3:0] i2, input int chg_j,
                           input logic [3:0] c1, input logic [3:0] c2, input bit poke,
                           input string tag);
    logic [3:0] m1, m2;
    logic [5:0] exp_v, got_v;
    logic [7:0] exp_q;
    int ch;
    d1_a = i1; d2_a = i2; m1 = 4'd0; m2 = 4'd0;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      if (j == chg_j) begin d1_a = c1; d2_a = c2; end
      bus1.start = poke && (j == 1 || j == 4 || j == 7 || j == 10);
      ch = j / 3;
      if (j < 12 && j % 3 == 2) begin m1[ch] = d1_a[ch]; m2[ch] = d2_a[ch]; end
      if (j < 12)       exp_v = {2'b00, 2'(ch), 1'b1, 1'b0};
      else if (j == 12) exp_v = 6'b111111;
      else              exp_v = 6'b110000;
      exp_q = (j < 12) ? {q1_1, q2_1} : {m1, m2};
      got_v = {bus1.G1_n, bus1.G2_n, bus1.S1, bus1.S0, bus1.busy, bus1.valid};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL %s_ctl j=%0d got %b want %b", tag, j, got_v, exp_v);
      end
      n_cmp++;
      if ({bus1.Q1, bus1.Q2} !== exp_q) begin
        n_fail++; $display("FAIL %s_q j=%0d got %h want %h", tag, j, {bus1.Q1, bus1.Q2}, exp_q);
      end
      @(posedge clk); #1;
    end
    bus1.start = 1'b0;
    q1_1 = m1; q2_1 = m2;
  endtask

  task automatic test_single_scan();
    run_scan1(4'b0110, 4'b1001, -1, 4'd0, 4'd0, 1'b0, "single");
    n_cmp++;
    if ({q1_1, q2_1} !== 8'b0110_1001 || {bus1.Q1, bus1.Q2} !== 8'b0110_1001) begin
      n_fail++; $display("FAIL single_words got %h want 69", {bus1.Q1, bus1.Q2});
    end
  endtask

  task automatic test_atomicity();
    run_scan1(4'b0110, 4'b1001, 6, 4'b1111, 4'b1001, 1'b0, "atomic");
    n_cmp++;
    if (bus1.Q1 !== 4'b1110) begin
      n_fail++; $display("FAIL atomic_q1 got %b want 1110", bus1.Q1);
    end
  endtask

  task automatic test_random_scans();
    for (int r = 0; r < 5; r++)
      run_scan1(4'($urandom), 4'($urandom), int'($urandom_range(0, 13)), 4'($urandom),
                4'($urandom), 1'b0, "rand");
  endtask

  task automatic test_start_ignored();
    run_scan1(4'($urandom), 4'($urandom), -1, 4'd0, 4'd0, 1'b1, "poke");
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (bus1.valid !== 1'b0 || bus1.busy !== 1'b0) begin
        n_fail++; $display("FAIL poke_tail j=%0d got v=%b b=%b want 0 0", j, bus1.valid,
                           bus1.busy);
      end
      @(posedge clk); #1;
    end
  endtask

  // SETTLE=0 instance in continuous mode: 9-cycle period, DONE at position 8.
  task automatic test_continuous();
    logic [3:0] m1, m2;
    logic [5:0] exp_v, got_v;
    logic [7:0] exp_q;
    int p, sc;
    m1 = 4'd0; m2 = 4'd0;
    d1_b = 4'($urandom); d2_b = 4'($urandom);
    bus0.cont = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j <= 6 * 9 + 2; j++) begin
      p = j % 9; sc = j / 9;
      if (sc < 6 && p == 0) begin d1_b = 4'($urandom); d2_b = 4'($urandom); end
      if (sc < 6 && p == 4 && $urandom_range(0, 1) == 1) d1_b = 4'($urandom);
      if (sc == 5 && p == 3) bus0.cont = 1'b0;
      if (sc < 6 && p < 8 && p % 2 == 1) begin
        m1[p / 2] = d1_b[p / 2]; m2[p / 2] = d2_b[p / 2];
      end
      if (sc == 6)     exp_v = 6'b110000;
      else if (p == 8) exp_v = 6'b111111;
      else             exp_v = {2'b00, 2'(p / 2), 1'b1, 1'b0};
      exp_q = (sc < 6 && p == 8) ? {m1, m2} : {q1_0, q2_0};
      got_v = {bus0.G1_n, bus0.G2_n, bus0.S1, bus0.S0, bus0.busy, bus0.valid};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL cont_ctl j=%0d got %b want %b", j, got_v, exp_v);
      end
      n_cmp++;
      if ({bus0.Q1, bus0.Q2} !== exp_q) begin
        n_fail++; $display("FAIL cont_q j=%0d got %h want %h", j, {bus0.Q1, bus0.Q2}, exp_q);
      end
      if (sc < 6 && p == 8) begin q1_0 = m1; q2_0 = m2; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [5:0] got;
    d1_a = 4'($urandom); d2_a = 4'($urandom);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({bus1.S1, bus1.S0, bus1.busy} !== 3'b101) begin
      n_fail++; $display("FAIL rstmid_pre got %b want 101", {bus1.S1, bus1.S0, bus1.busy});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q1_1 = 4'd0; q2_1 = 4'd0; q1_0 = 4'd0; q2_0 = 4'd0;
    for (int j = 0; j < 14; j++) begin
      got = {bus1.G1_n, bus1.G2_n, bus1.S1, bus1.S0, bus1.busy, bus1.valid};
      n_cmp++;
      if (got !== 6'b110000 || {bus1.Q1, bus1.Q2} !== 8'h00) begin
        n_fail++; $display("FAIL rstmid_idle j=%0d got %b q=%h want 110000 q=00", j, got,
                           {bus1.Q1, bus1.Q2});
      end
      @(posedge clk); #1;
    end
    run_scan1(4'($urandom), 4'($urandom), -1, 4'd0, 4'd0, 1'b0, "after_rst");
  endtask

  initial begin
    rst = 1'b1;
    bus1.start = 1'b0; bus1.cont = 1'b0;
    bus0.start = 1'b0; bus0.cont = 1'b0;
    d1_a = 4'd0; d2_a = 4'd0; d1_b = 4'd0; d2_b = 4'd0;
    q1_1 = 4'd0; q2_1 = 4'd0; q1_0 = 4'd0; q2_0 = 4'd0;
    @(negedge clk);
    test_reset();
    test_single_scan();
    test_atomicity();
    test_random_scans();
    test_start_ignored();
    test_continuous();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
